cdb_broadcast_arbiter: RTL and testbench

- Producer end of the 3-wide complete-bus write interface consumed by the physical register file.
- Collects results from NUM_FU functional units, each through a one-entry holding buffer with valid/ready handshake.
- Each cycle, round-robin selects up to three held results and drives them as a CDB_T_PACKET (slots t0/t1/t2) plus a 3-lane write-data bus.
- Sits between the execute stage and the register file / reservation-station wakeup logic.

---
 rtl/cdb_broadcast_arbiter.sv | 96 +++++++++
 tb/tb_cdb_broadcast_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcast_arbiter.sv
// rtl/cdb_broadcast_arbiter.sv - round-robin 3-wide complete-bus broadcaster fed by per-FU holding buffers
// Slot k of cdb_out/wr_data is CDB tk; an empty slot carries ZERO_PR and zero data.
module cdb_broadcast_arbiter #(
  parameter int              NUM_FU  = 6,
  parameter int              PR_W    = 6,
  parameter int              XLEN_W  = 32,
  parameter logic [PR_W-1:0] ZERO_PR = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][PR_W-1:0]    fu_tag,
  input  logic [NUM_FU-1:0][XLEN_W-1:0]  fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
  output logic [2:0][PR_W-1:0]           cdb_out,
  output logic [2:0][XLEN_W-1:0]         wr_data
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]             hold_valid_q, hold_valid_d;
  logic [NUM_FU-1:0][PR_W-1:0]   hold_tag_q, hold_tag_d;
  logic [NUM_FU-1:0][XLEN_W-1:0] hold_data_q, hold_data_d;
  logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;

  logic [NUM_FU-1:0]             grant;
  logic                          any_grant;
  logic [IDX_W-1:0]              last_idx;

  // Scan from rr_ptr with wraparound; slots fill strictly t0, t1, t2.
  always_comb begin
    int idx;
    int n_grant;
    grant     = '0;
    any_grant = 1'b0;
    last_idx  = '0;
    n_grant   = 0;
    for (int k = 0; k < 3; k++) begin
      cdb_out[k] = ZERO_PR;
      wr_data[k] = '0;
    end
    for (int off = 0; off < NUM_FU; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!squash && hold_valid_q[idx] && n_grant < 3) begin
        grant[idx]       = 1'b1;
        cdb_out[n_grant] = hold_tag_q[idx];
        wr_data[n_grant] = hold_data_q[idx];
        n_grant          = n_grant + 1;
        any_grant        = 1'b1;
        last_idx         = IDX_W'(idx);
      end
    end
  end

  assign fu_ready = squash ? '0 : (~hold_valid_q | grant);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_idx == IDX_W'(NUM_FU - 1)) ? '0 : last_idx + IDX_W'(1);
    end
  end

  // A ZERO_PR result has no destination: it is accepted but never held.
  always_comb begin
    hold_valid_d = hold_valid_q & ~grant;
    hold_tag_d   = hold_tag_q;
    hold_data_d  = hold_data_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (squash) begin
        hold_valid_d[i] = 1'b0;
      end else if (fu_valid[i] && fu_ready[i] && fu_tag[i] != ZERO_PR) begin
        hold_valid_d[i] = 1'b1;
        hold_tag_d[i]   = fu_tag[i];
        hold_data_d[i]  = fu_data[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_q <= '0;
      hold_tag_q   <= '0;
      hold_data_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_tag_q   <= hold_tag_d;
      hold_data_q  <= hold_data_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// tb/tb_cdb_broadcast_arbiter.sv - directed-vector self-checking bench for cdb_broadcast_arbiter
module tb_cdb_broadcast_arbiter;

  localparam int NUM_FU = 6;
  localparam int PR_W   = 6;
  localparam int XLEN_W = 32;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          squash;
  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0][PR_W-1:0]   fu_tag;
  logic [NUM_FU-1:0][XLEN_W-1:0] fu_data;
  logic [NUM_FU-1:0]             fu_ready;
  logic [2:0][PR_W-1:0]          cdb_out;
  logic [2:0][XLEN_W-1:0]        wr_data;

  int checks = 0;
  int errors = 0;

  cdb_broadcast_arbiter #(.NUM_FU(NUM_FU), .PR_W(PR_W), .XLEN_W(XLEN_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .squash   (squash),
    .fu_valid (fu_valid),
    .fu_tag   (fu_tag),
    .fu_data  (fu_data),
    .fu_ready (fu_ready),
    .cdb_out  (cdb_out),
    .wr_data  (wr_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] cdb3(input int t0, input int t1, input int t2);
    logic [2:0][PR_W-1:0] v;
    v[0] = PR_W'(t0);
    v[1] = PR_W'(t1);
    v[2] = PR_W'(t2);
    return 128'(v);
  endfunction

  function automatic logic [127:0] wd3(input int d0, input int d1, input int d2);
    logic [2:0][XLEN_W-1:0] v;
    v[0] = XLEN_W'(d0);
    v[1] = XLEN_W'(d1);
    v[2] = XLEN_W'(d2);
    return 128'(v);
  endfunction

  task automatic idle_inputs();
    squash   = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    chk("reset_cdb", 128'(cdb_out), cdb3(0, 0, 0));
    chk("reset_wr", 128'(wr_data), wd3(0, 0, 0));
    chk("reset_ready", 128'(fu_ready), 128'(6'b111111));
    chk("reset_rr", 128'(dut.rr_ptr_q), 128'(0));

    // Two sources, slots fill in order with rr starting at 0
    fu_valid[1] = 1'b1; fu_tag[1] = 6'd5; fu_data[1] = 32'hA;
    fu_valid[4] = 1'b1; fu_tag[4] = 6'd9; fu_data[4] = 32'hB;
    #1;
    chk("two_ready", 128'(fu_ready), 128'(6'b111111));
    tick();
    idle_inputs();
    #1;
    chk("two_cdb", 128'(cdb_out), cdb3(5, 9, 0));
    chk("two_wr", 128'(wr_data), wd3(32'hA, 32'hB, 0));
    tick();
    chk("two_rr", 128'(dut.rr_ptr_q), 128'(5));
    chk("two_idle", 128'(cdb_out), cdb3(0, 0, 0));

    // All six sources: two broadcast cycles
    do_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      fu_valid[i] = 1'b1;
      fu_tag[i]   = PR_W'(10 + i);
      fu_data[i]  = XLEN_W'(32'h100 + i);
    end
    tick();
    idle_inputs();
    #1;
    chk("all_c1_cdb", 128'(cdb_out), cdb3(10, 11, 12));
    chk("all_c1_wr", 128'(wr_data), wd3(32'h100, 32'h101, 32'h102));
    chk("all_c1_ready", 128'(fu_ready), 128'(6'b000111));
    tick();
    chk("all_c2_rr", 128'(dut.rr_ptr_q), 128'(3));
    chk("all_c2_cdb", 128'(cdb_out), cdb3(13, 14, 15));
    chk("all_c2_wr", 128'(wr_data), wd3(32'h103, 32'h104, 32'h105));
    chk("all_c2_ready", 128'(fu_ready), 128'(6'b111111));
    tick();
    chk("all_c3_cdb", 128'(cdb_out), cdb3(0, 0, 0));
    chk("all_c3_rr", 128'(dut.rr_ptr_q), 128'(0));

    // Tag zero is accepted and dropped
    fu_valid[2] = 1'b1; fu_tag[2] = 6'd0; fu_data[2] = 32'h55;
    #1;
    chk("zero_ready", 128'(fu_ready[2]), 128'(1));
    tick();
    idle_inputs();
    #1;
    chk("zero_cdb", 128'(cdb_out), cdb3(0, 0, 0));
    chk("zero_wr", 128'(wr_data), wd3(0, 0, 0));
    chk("zero_ready_after", 128'(fu_ready), 128'(6'b111111));

    // Squash with five held results
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fu_valid[i] = 1'b1;
      fu_tag[i]   = PR_W'(1 + i);
      fu_data[i]  = XLEN_W'(32'h20 + i);
    end
    tick();
    idle_inputs();
    squash      = 1'b1;
    fu_valid[5] = 1'b1; fu_tag[5] = 6'd33; fu_data[5] = 32'h77;
    #1;
    chk("sq_cdb", 128'(cdb_out), cdb3(0, 0, 0));
    chk("sq_wr", 128'(wr_data), wd3(0, 0, 0));
    chk("sq_ready", 128'(fu_ready), 128'(6'b000000));
    tick();
    idle_inputs();
    #1;
    chk("sq_after_cdb", 128'(cdb_out), cdb3(0, 0, 0));
    chk("sq_after_ready", 128'(fu_ready), 128'(6'b111111));
    chk("sq_after_rr", 128'(dut.rr_ptr_q), 128'(0));
    fu_valid[3] = 1'b1; fu_tag[3] = 6'd7; fu_data[3] = 32'h70;
    tick();
    idle_inputs();
    #1;
    chk("sq_new_cdb", 128'(cdb_out), cdb3(7, 0, 0));
    chk("sq_new_wr", 128'(wr_data), wd3(32'h70, 0, 0));
    tick();

    // Back-to-back stream on source 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        fu_valid[0] = 1'b1;
        fu_tag[0]   = PR_W'(20 + k);
        fu_data[0]  = XLEN_W'(32'h200 + k);
      end else begin
        idle_inputs();
      end
      #1;
      chk($sformatf("b2b_ready_%0d", k), 128'(fu_ready[0]), 128'(1));
      if (k > 0) begin
        chk($sformatf("b2b_cdb_%0d", k), 128'(cdb_out), cdb3(19 + k, 0, 0));
        chk($sformatf("b2b_wr_%0d", k), 128'(wr_data), wd3(32'h1FF + k, 0, 0));
      end
      tick();
    end
    chk("b2b_idle", 128'(cdb_out), cdb3(0, 0, 0));

    // Reset overrides squash and in-flight accepts, dropping held results
    for (int i = 0; i < 3; i++) begin
      fu_valid[i] = 1'b1;
      fu_tag[i]   = PR_W'(40 + i);
      fu_data[i]  = XLEN_W'(32'h400 + i);
    end
    tick();
    reset  = 1'b1;
    squash = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst_mid_cdb", 128'(cdb_out), cdb3(0, 0, 0));
    chk("rst_mid_ready", 128'(fu_ready), 128'(6'b111111));
    chk("rst_mid_rr", 128'(dut.rr_ptr_q), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
